// File: rtl/osmlgd_frame_loader.sv
// osmlgd_frame_loader
// Assembles a stream of WORD_W-bit words into DATA_W-bit frames held in two
// ping-pong buffers, then launches each complete frame into the OSMLGD decoder
// with a one-cycle work pulse. tx is held stable until the decoder reports
// valid. The next frame fills while the current one is being decoded.
module osmlgd_frame_loader #(
    parameter int DATA_W = 256,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              free,
    input  logic              dec_valid,
    output logic [DATA_W-1:0] tx,
    output logic              work,
    output logic [15:0]       frames_launched
);

    localparam int NWORDS = DATA_W / WORD_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        L_IDLE,
        L_WAIT,
        L_HOLD
    } lstate_t;

    lstate_t           state, state_next;
    logic [DATA_W-1:0] frame_buf [2];
    logic [1:0]        full, full_next;
    logic              fill_ptr, fill_ptr_next;
    // Buffer owned by the launch side. Frames fill alternately, so the
    // oldest full buffer is always the one this pointer names.
    logic              launch_ptr;
    logic [IDX_W-1:0]  word_idx;
    logic              accept;
    logic              frame_done;
    logic              release_buf;

    assign accept     = in_valid && in_ready;
    assign frame_done = accept && (word_idx == LAST_IDX);

    // Launch FSM next state, work pulse and buffer occupancy updates.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_next    = state;
        work          = 1'b0;
        release_buf   = 1'b0;
        full_next     = full;
        fill_ptr_next = fill_ptr;

        if (frame_done) begin
            full_next[fill_ptr] = 1'b1;
            fill_ptr_next       = !fill_ptr;
        end

        case (state)
            L_IDLE: begin
                if (full[launch_ptr]) state_next = L_WAIT;
            end
            L_WAIT: begin
                // work is combinational so it follows free in the same cycle
                // and drops the instant reset forces the FSM back to idle.
                if (free) begin
                    work       = 1'b1;
                    state_next = L_HOLD;
                end
            end
            L_HOLD: begin
                if (dec_valid) begin
                    release_buf = 1'b1;
                    state_next  = L_IDLE;
                end
            end
            default: state_next = L_IDLE;
        endcase

        // The released buffer is full, the filling one is not, so these two
        // updates never touch the same entry.
        if (release_buf) full_next[launch_ptr] = 1'b0;
    end

    // Control state, handshake, launch register and counter.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (!rst) begin
            state           <= L_IDLE;
            full            <= 2'b00;
            fill_ptr        <= 1'b0;
            launch_ptr      <= 1'b0;
            word_idx        <= '0;
            in_ready        <= 1'b0;
            tx              <= '0;
            frames_launched <= 16'd0;
        end else begin
            state    <= state_next;
            full     <= full_next;
            fill_ptr <= fill_ptr_next;
            in_ready <= !full_next[fill_ptr_next];

            if (accept) word_idx <= frame_done ? '0 : word_idx + IDX_W'(1);
            if (release_buf) launch_ptr <= !launch_ptr;
            if (state == L_IDLE && full[launch_ptr]) tx <= frame_buf[launch_ptr];
            if (work) frames_launched <= frames_launched + 16'd1;
        end
    end

    // Frame storage: each accepted word lands in its slot of the fill buffer.
    always_ff @(posedge clk) begin
        // NOTE: the data array has no reset; the full flags alone say whether
        // a buffer holds a frame, so stale contents are never observed.
        if (accept) frame_buf[fill_ptr][WORD_W*word_idx +: WORD_W] <= in_data;
    end

endmodule

// File: doc/osmlgd_frame_loader.md
Name: osmlgd_frame_loader

Overview:
- Upstream feeder for the OSMLGD decoder top.
- Accepts received codeword bits as a stream of WORD_W-bit words with a valid/ready handshake and assembles them into DATA_W-bit frames in two ping-pong buffers.
- Launches each frame into the decoder with a one-cycle `work` pulse and holds `tx` stable until the decoder reports `valid`.
- Filling of the next frame overlaps decoding of the current one.

Parameters:
- DATA_W, 256, codeword width; equals decoder `tx` width.
- WORD_W, 32, input word width; DATA_W must be an integer multiple of WORD_W.
- NWORDS, DATA_W/WORD_W (8), words per frame; derived, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- in_data  input  WORD_W  received word.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts in_data this cycle.
- free  input  1  decoder idle; connects to decoder `free`.
- dec_valid  input  1  decoder output-valid pulse; connects to decoder `valid`.
- tx  output  DATA_W  frame driven to decoder `tx`.
- work  output  1  one-cycle launch pulse to decoder `work`.
- frames_launched  output  16  count of work pulses issued; wraps modulo 2^16.

Behaviour:
- Reset (rst=0, asynchronous) clears the following:
  - in_ready=0, work=0, tx=0, frames_launched=0.
  - Both buffers empty; fill pointer = buffer 0; word index = 0; launch FSM = L_IDLE.
- First cycle after reset release: in_ready=1.
- Fill side:
  - A transfer occurs when in_valid && in_ready.
  - Word k of a frame (k = 0..NWORDS-1) is written to bits [WORD_W*k+WORD_W-1 : WORD_W*k] of the fill buffer.
  - On word NWORDS-1 the fill buffer is marked full, the fill pointer toggles, and the word index resets to 0.
  - in_ready = !full[fill pointer], registered so it reflects the state after the current cycle's updates.
- Launch FSM:
  - L_IDLE:
    - If a buffer is full, select it: the older one if both are full (launch order = fill order).
    - tx <= selected buffer; go to L_WAIT.
  - L_WAIT:
    - If free=1: work <= 1 for exactly one cycle; frames_launched increments; go to L_HOLD.
    - If free=0: stay in L_WAIT with work=0.
  - L_HOLD:
    - tx held constant.
    - On dec_valid=1: mark the launched buffer empty; go to L_IDLE.
- Latency: with decoder free and the frame complete on cycle T, tx is valid at T+2 and work pulses at T+2.
- Simultaneous events:
  - Fill completion and dec_valid in the same cycle: both take effect. Freeing one buffer and filling the other never conflict.
  - When a buffer is freed, in_ready rises on the next cycle if that buffer is the fill target.
- dec_valid outside L_HOLD is ignored; no state change.
- Partial frames are never launched and have no timeout.
- Reset mid-operation discards partial and full buffers. work drops immediately, asynchronously.
- tx changes only on the L_IDLE→L_WAIT transition.
- work is never asserted while free=0 and is never asserted twice for one frame.

Test Plan:
- Reset, then stream words 0x00000001..0x00000008 with in_valid held high, free=1 → work pulses once; tx = 0x00000008_00000007_..._00000001; frames_launched=1.
- Hold free=0 after a full frame → work stays 0 and tx stable. Raise free at cycle 20 → single work pulse in that cycle.
- Stream 24 words continuously while dec_valid arrives 12 cycles after each work:
  - frames 1 and 2 buffered; in_ready=0 during words 17–24 until the first dec_valid;
  - three work pulses in order; frames_launched=3.
- dec_valid pulse while in L_IDLE with one partial frame of 5 words → no state change; that frame completes after 3 more words and launches normally.
- Pull rst low during L_HOLD with the second buffer half full → all outputs 0 immediately; the next 8 words form a fresh frame with word 0 in tx[31:0].
- Force frames_launched to 0xFFFF, launch one frame → counter wraps to 0x0000.
